sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Synchronous, loadable down-counter/timer for the counter library. It complements the ripple up-counter by counting in the opposite direction. Unlike the ripple counter, every bit changes on one clock edge, so Q is glitch-free and safe to decode. It supplies one-shot and periodic terminal-count pulses to downstream control logic.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16
- CLK  input  1  clock; all state changes on the rising edge
- Reset  input  1  asynchronous, active-high reset
- Load  input  1  synchronous load strobe; highest priority after Reset
- Load_Value  input  WIDTH  start value, captured when Load=1
- Enable  input  1  count enable; one decrement per clock edge with Enable=1 in RUN
- Auto_Reload  input  1  1 = periodic mode, 0 = one-shot; sampled at the terminal edge
- Q  output  WIDTH  current count, registered
- TC  output  1  terminal-count pulse, registered, high for exactly one cycle
- Busy  output  1  high while the FSM is in RUN
- Done  output  1  high while the FSM is in DONE (one-shot expired)

## Operation
- Reset (asynchronous, any time, including mid-count) forces the following immediately, without waiting for a clock edge:
  - Q=0, TC=0, Busy=0, Done=0
  - reload register = 0
  - FSM = IDLE
- FSM states: IDLE, RUN, DONE. Busy and Done are decoded from state only, with no combinational input paths.
- Load=1, from any state:
  - Q <= Load_Value and reload register <= Load_Value.
  - Next state is RUN if Load_Value != 0, otherwise IDLE.
  - TC=0 in the following cycle.
  - Enable is ignored in the Load cycle.
- RUN with Enable=1 and Q > 1: Q <= Q - 1.
- RUN with Enable=1 and Q == 1 (terminal edge):
  - Auto_Reload=1: Q <= reload register, state stays RUN, TC=1 next cycle.
  - Auto_Reload=0: Q <= 0, state goes to DONE, TC=1 next cycle.
- RUN with Enable=0: Q, state and TC=0 held.
- IDLE and DONE: Q held. Enable and Auto_Reload are ignored. Only Load (or Reset) leaves these states.
- Q never wraps below 0. No decrement occurs from Q=0 in any state.
- Auto_Reload changes outside the terminal edge have no effect.

## Timing
- Every output is a flop output. There is no combinational path from input to output.
- Load latency: one cycle. Q shows Load_Value after the first rising edge with Load=1.
- Periodic mode with reload value N:
  - TC period is exactly N enabled cycles.
  - Q sequence: N, N-1, …, 1, N, …
  - TC is high in the cycle in which Q first shows N again.
- One-shot mode with value N:
  - TC rises N enabled edges after the load edge.
  - In that same cycle, Q=0, Busy=0 and Done=1.
  - TC falls after one cycle. Done stays high until Load.
- Load_Value = 1: the first enabled edge is the terminal edge.
- Simultaneous Load and terminal edge: Load wins, and no TC is generated.
- Reset released mid-cycle: the first active edge after deassertion behaves as if from IDLE. Reset and deassertion synchronization is the integrator's responsibility.

## Test plan
- Reset mid-count:
  - Stimulus: WIDTH=4, load 9 and run 3 enabled cycles (Q=6), then pulse Reset between clock edges.
  - Required: Q=0, Busy=0 and Done=0 before the next edge; TC is never asserted.
- One-shot countdown:
  - Stimulus: Load_Value=5, Auto_Reload=0, Enable=1.
  - Required: Q goes 5,4,3,2,1,0. TC=1 only in the cycle with Q=0. Done=1 from then on. Q stays 0 for 10 more enabled cycles.
- Periodic mode:
  - Stimulus: Load_Value=3, Auto_Reload=1, Enable=1 for 12 cycles.
  - Required: Q goes 3,2,1,3,2,1,… and TC pulses every 3rd cycle, 4 times in total.
- Enable gating:
  - Stimulus: Load_Value=4, then toggle Enable 1,0,0,1,1,1.
  - Required: Q goes 3,3,3,2,1,0. TC fires once, aligned with Q=0.
- Load collision:
  - Stimulus: Q=1 in RUN, then Load=1 with Load_Value=7 in the same cycle as Enable=1.
  - Required: Q=7, TC=0, Busy=1.
- Width extremes:
  - Stimulus: WIDTH=16, Load_Value=16'hFFFF, one-shot.
  - Required: TC rises exactly 65535 enabled edges after the load edge. Load_Value=0 gives IDLE, Busy=0 and no TC.

Source files
------------

// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter: load/enable strobes in, count and flags out.
interface sync_down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             Load;
  logic [WIDTH-1:0] Load_Value;
  logic             Enable;
  logic             Auto_Reload;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Busy;
  logic             Done;

  modport master (
    output Load, Load_Value, Enable, Auto_Reload,
    input  Q, TC, Busy, Done
  );

  modport slave (
    input  Load, Load_Value, Enable, Auto_Reload,
    output Q, TC, Busy, Done
  );
endinterface

// File: rtl/sync_down_counter.sv
// Synchronous loadable down-counter/timer with one-shot and periodic terminal-count pulses.
// Every output is a flop; Busy/Done are registered copies of the FSM state.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input logic              CLK,
  input logic              Reset,
  sync_down_counter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      reload   <= '0;
      bus.Q    <= '0;
      bus.TC   <= 1'b0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      bus.TC <= 1'b0;
      if (bus.Load) begin
        // Load beats everything, including a coincident terminal edge
        bus.Q    <= bus.Load_Value;
        reload   <= bus.Load_Value;
        bus.Done <= 1'b0;
        if (bus.Load_Value != '0) begin
          state    <= RUN;
          bus.Busy <= 1'b1;
        end else begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      end else if (state == RUN && bus.Enable) begin
        if (bus.Q == WIDTH'(1)) begin
          bus.TC <= 1'b1;
          if (bus.Auto_Reload) begin
            bus.Q <= reload;
          end else begin
            bus.Q    <= '0;
            state    <= DONE;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
          end
        end else if (bus.Q != '0) begin
          bus.Q <= bus.Q - WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: 4-bit instance for behaviour, 16-bit for the width extreme.
module tb_sync_down_counter;
  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  sync_down_counter_if #(.WIDTH(4))  b4 ();
  sync_down_counter_if #(.WIDTH(16)) b16 ();

  sync_down_counter #(.WIDTH(4))  dut4  (.CLK(CLK), .Reset(Reset), .bus(b4));
  sync_down_counter #(.WIDTH(16)) dut16 (.CLK(CLK), .Reset(Reset), .bus(b16));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load4(input logic [3:0] v, input logic ar, input logic en);
    b4.Load        = 1'b1;
    b4.Load_Value  = v;
    b4.Auto_Reload = ar;
    b4.Enable      = en;
    tick();
    b4.Load = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    b4.Load = 1'b0; b4.Load_Value = '0; b4.Enable = 1'b0; b4.Auto_Reload = 1'b0;
    b16.Load = 1'b0; b16.Load_Value = '0; b16.Enable = 1'b0; b16.Auto_Reload = 1'b0;
    #3;
    checks++;
    if (b4.Q !== 4'd0 || b4.TC !== 1'b0 || b4.Busy !== 1'b0 || b4.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%0d TC=%b Busy=%b Done=%b, want 0 0 0 0", b4.Q, b4.TC, b4.Busy, b4.Done);
    end
    tick(); tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (b4.Q !== 4'd0 || b4.Busy !== 1'b0 || b16.Q !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: Q4=%0d Busy=%b Q16=%0d, want 0 0 0", b4.Q, b4.Busy, b16.Q);
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    load4(4'd5, 1'b0, 1'b1);
    checks++;
    if (b4.Q !== 4'd5 || b4.Busy !== 1'b1 || b4.TC !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_load: Q=%0d Busy=%b TC=%b, want 5 1 0", b4.Q, b4.Busy, b4.TC);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b4.Q !== exp_q[i] || b4.TC !== (i == 4) || b4.Done !== (i == 4) || b4.Busy !== (i != 4)) begin
        errors++;
        $display("FAIL oneshot_step%0d: Q=%0d TC=%b Done=%b Busy=%b, want %0d %b %b %b",
                 i, b4.Q, b4.TC, b4.Done, b4.Busy, exp_q[i], i == 4, i == 4, i != 4);
      end
    end
    b4.Auto_Reload = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (b4.Q !== 4'd0 || b4.TC !== 1'b0 || b4.Done !== 1'b1 || b4.Busy !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_hold%0d: Q=%0d TC=%b Done=%b Busy=%b, want 0 0 1 0", i, b4.Q, b4.TC, b4.Done, b4.Busy);
      end
    end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_q [3] = '{4'd2, 4'd1, 4'd3};
    int tc_count = 0;
    load4(4'd3, 1'b1, 1'b1);
    checks++;
    if (b4.Q !== 4'd3 || b4.Done !== 1'b0 || b4.Busy !== 1'b1) begin
      errors++;
      $display("FAIL periodic_load: Q=%0d Done=%b Busy=%b, want 3 0 1", b4.Q, b4.Done, b4.Busy);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b4.TC === 1'b1) tc_count++;
      checks++;
      if (b4.Q !== exp_q[i % 3] || b4.TC !== ((i % 3) == 2) || b4.Busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_step%0d: Q=%0d TC=%b Busy=%b, want %0d %b 1", i, b4.Q, b4.TC, b4.Busy, exp_q[i % 3], (i % 3) == 2);
      end
    end
    checks++;
    if (tc_count != 4) begin
      errors++;
      $display("FAIL periodic_tc_count: got %0d, want 4", tc_count);
    end
  endtask

  task automatic test_enable_gating();
    logic       en_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_q  [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    load4(4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      b4.Enable = en_seq[i];
      tick();
      checks++;
      if (b4.Q !== exp_q[i] || b4.TC !== (i == 5)) begin
        errors++;
        $display("FAIL gating_step%0d: Q=%0d TC=%b, want %0d %b", i, b4.Q, b4.TC, exp_q[i], i == 5);
      end
    end
  endtask

  task automatic test_load_collision();
    load4(4'd2, 1'b0, 1'b1);
    tick();
    checks++;
    if (b4.Q !== 4'd1 || b4.Busy !== 1'b1) begin
      errors++;
      $display("FAIL collision_pre: Q=%0d Busy=%b, want 1 1", b4.Q, b4.Busy);
    end
    load4(4'd7, 1'b0, 1'b1);
    checks++;
    if (b4.Q !== 4'd7 || b4.TC !== 1'b0 || b4.Busy !== 1'b1 || b4.Done !== 1'b0) begin
      errors++;
      $display("FAIL collision: Q=%0d TC=%b Busy=%b Done=%b, want 7 0 1 0", b4.Q, b4.TC, b4.Busy, b4.Done);
    end
  endtask

  task automatic test_load_edges();
    load4(4'd1, 1'b0, 1'b1);
    tick();
    checks++;
    if (b4.Q !== 4'd0 || b4.TC !== 1'b1 || b4.Done !== 1'b1) begin
      errors++;
      $display("FAIL load_one: Q=%0d TC=%b Done=%b, want 0 1 1", b4.Q, b4.TC, b4.Done);
    end
    load4(4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b4.Q !== 4'd0 || b4.TC !== 1'b0 || b4.Busy !== 1'b0 || b4.Done !== 1'b0) begin
        errors++;
        $display("FAIL load_zero%0d: Q=%0d TC=%b Busy=%b Done=%b, want 0 0 0 0", i, b4.Q, b4.TC, b4.Busy, b4.Done);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    bit tc_seen = 0;
    load4(4'd9, 1'b0, 1'b1);
    tick(); tick(); tick();
    checks++;
    if (b4.Q !== 4'd6) begin
      errors++;
      $display("FAIL midreset_pre: Q=%0d, want 6", b4.Q);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (b4.Q !== 4'd0 || b4.Busy !== 1'b0 || b4.Done !== 1'b0 || b4.TC !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: Q=%0d Busy=%b Done=%b TC=%b, want 0 0 0 0", b4.Q, b4.Busy, b4.Done, b4.TC);
    end
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b4.TC === 1'b1 || b4.Q !== 4'd0) tc_seen = 1;
    end
    checks++;
    if (tc_seen) begin
      errors++;
      $display("FAIL midreset_idle: TC or nonzero Q after reset release, want Q=0 TC=0");
    end
  endtask

  task automatic test_width16();
    int edges = 0;
    b16.Load = 1'b1; b16.Load_Value = 16'hFFFF; b16.Auto_Reload = 1'b0; b16.Enable = 1'b1;
    tick();
    b16.Load = 1'b0;
    while (b16.TC !== 1'b1 && edges < 70000) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 65535 || b16.Q !== 16'd0 || b16.Done !== 1'b1) begin
      errors++;
      $display("FAIL width16_terminal: edges=%0d Q=%0d Done=%b, want 65535 0 1", edges, b16.Q, b16.Done);
    end
    b16.Load = 1'b1; b16.Load_Value = 16'd0;
    tick();
    b16.Load = 1'b0;
    tick();
    checks++;
    if (b16.Busy !== 1'b0 || b16.TC !== 1'b0 || b16.Done !== 1'b0 || b16.Q !== 16'd0) begin
      errors++;
      $display("FAIL width16_zero: Busy=%b TC=%b Done=%b Q=%0d, want 0 0 0 0", b16.Busy, b16.TC, b16.Done, b16.Q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gating();
    test_load_collision();
    test_load_edges();
    test_reset_mid_count();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
